q_episode_ctrl: RTL
===================

// Module: q_episode_ctrl
// PURPOSE
//  Sequences Q-learning training episodes on the 6x6 maze (states 1..36, actions 0=N 1=E 2=S 3=W).
//  Owns the single read/write port of the Q table (37x4 x 32b, row 0 unused) and runs each step: read, act, move, update.
//  Sits between the maze configuration (start/target/blocked) and the Q-table RAM.
//  Runs NUM_EPISODES episodes per start pulse.
// PARAMETERS
//  NUM_EPISODES  16     episodes per start command (1..65535)
//  MAX_STEPS     255    step limit per episode before forced end
//  ALPHA_SH      2      learning rate alpha = 2^-ALPHA_SH
//  GAMMA_SH      3      discount gamma = 1 - 2^-GAMMA_SH
//  REWARD        32'd1024  reward for entering target_state
// PORTS
//  clk           in   1    clock
//  rst           in   1    async reset, active-high
//  start         in   1    one-cycle pulse: begin training run (ignored while busy)
//  start_state   in   6    episode start state (1..36)
//  target_state  in   6    goal state (1..36)
//  blocked_mask  in   37   bit s=1 -> state s is blocked (bit 0 ignored); stable while busy
//  q_addr        out  8    Q RAM address {state[5:0],action[1:0]}
//  q_rd_en       out  1    read strobe; q_rdata valid the following cycle
//  q_rdata       in   32   Q RAM read data
//  q_wr_en       out  1    write strobe
//  q_wdata       out  32   write data
//  busy          out  1    high from cycle after accepted start until done
//  done          out  1    one-cycle pulse at end of run
//  err           out  1    sticky until next start: illegal start/target config
//  cur_state     out  6    agent position
//  episode_cnt   out  16   completed episodes in this run
//  step_cnt      out  8    steps taken in current episode
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; cur_state=0; q_wr_en drops asynchronously (any in-flight write is abandoned).
//  FSM: IDLE -> CHECK -> INIT -> RD_CUR -> SELECT -> MOVE -> RD_NXT -> UPDATE -> WRITE -> EP_END/RD_CUR; EP_END -> INIT | FIN -> IDLE.
//  CHECK: start_state or target_state outside 1..36, or either blocked -> err=1, go to FIN (done pulse, 0 episodes).
//  INIT: cur_state<=start_state, step_cnt<=0; if start==target -> EP_END directly (episode counts, 0 steps).
//  RD_CUR: 4 reads a=0..3 in consecutive cycles, data captured a cycle later; 5 cycles total.
//  SELECT (1 cyc): greedy action = argmax Q[s][a]; ties -> lowest action index.
//  MOVE (1 cyc): next = s-6 (N, row>0), s+1 (E, col<5), s+6 (S, row<5), s-1 (W, col>0); row=(s-1)/6, col=(s-1)%6.
//   Off-grid or blocked next -> next=s, r=0, no RD_NXT; UPDATE writes 0 to Q[s][a] (wall marker).
//   next==target -> r=REWARD, max_next=0 (terminal), RD_NXT skipped; else r=0, RD_NXT reads 4 values of next (5 cyc).
//  UPDATE: td = r + max_next - (max_next>>GAMMA_SH); q_new = q_old - (q_old>>ALPHA_SH) + (td>>ALPHA_SH);
//   34-bit intermediate, unsigned, saturate to 32'hFFFF_FFFF.
//  WRITE (1 cyc): q_wr_en=1, q_addr={s,a}, q_wdata=q_new; cur_state<=next; step_cnt++.
//  Episode end after WRITE when cur_state==target or step_cnt==MAX_STEPS; episode_cnt++;
//   -> INIT if episode_cnt<NUM_EPISODES else FIN.
//  FIN: done=1 for one cycle, busy=0, -> IDLE; episode_cnt/step_cnt/cur_state hold until next start.
//  q_rd_en and q_wr_en never high in the same cycle; at most one RAM access per cycle.
//  start during busy: ignored, no state change. start in the done cycle: ignored; accepted from IDLE only.
// CONFIGURATION
//  Q_EXPLORE_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset), advanced every cycle.
//   In SELECT, if lfsr[3:0]==0 (epsilon=1/16) action=lfsr[5:4], else greedy.
//  Q_EXPLORE_EN undefined: no LFSR; SELECT is purely greedy with lowest-index tie-break (fully deterministic).
// STRUCTURE
//  Package q_maze_pkg: GRID_W=6, N_STATES=36, state_t (logic[5:0]), action_e enum {ACT_N,ACT_E,ACT_S,ACT_W},
//   q_val_t (logic[31:0]), FSM state enum.
//  Sub-module q_next_state (combinational): state, action, blocked_mask -> next_state, legal.
//  Under Q_EXPLORE_EN the LFSR is an always_ff inside q_episode_ctrl; no separate module.
// TESTING
//  Bench Q RAM is a 256x32 behavioural model with 1-cycle read latency; run without Q_EXPLORE_EN unless stated.
//  1. All-zero Q, start=35, target=36, no blocks, NUM_EPISODES=1 -> a=N picked, 35->29; after MAX_STEPS done, err=0.
//  2. Preload Q[35][1]=100, start=35, target=36 -> write Q[35][1]=100-25+256=331, cur_state=36, step_cnt=1, done pulse.
//  3. start=1, Q[1][3] largest (west wall) -> Q[1][3] written 0, cur_state stays 1, step_cnt=1.
//  4. blocked_mask bit 7, start=1, Q[1][2] max -> Q[1][2]=0, no move; blocked start_state=7 -> err=1, done, 0 writes.
//  5. Assert rst mid-WRITE -> q_wr_en falls same cycle, busy=0, cur_state=0; new start runs normally from INIT.
//  6. Q_EXPLORE_EN, 4096 SELECTs -> random pick in 256+/-48 of them; reset reseeds identical action sequence.

Source files
------------

// File: rtl/q_maze_pkg.sv
// Shared types for the 6x6 maze Q-learning controller.
// Grid geometry, action/FSM enums and Q value type.
package q_maze_pkg;

  localparam int GRID_W   = 6;
  localparam int N_STATES = 36;

  typedef logic [5:0]  state_t;
  typedef logic [31:0] q_val_t;

  typedef enum logic [1:0] {
    ACT_N, ACT_E, ACT_S, ACT_W
  } action_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_INIT, S_RD_CUR,
    S_SELECT, S_MOVE, S_RD_NXT, S_UPDATE,
    S_WRITE, S_EP_END, S_FIN
  } fsm_e;

  function automatic logic on_grid(state_t s);
    return (s != 6'd0) && (s <= 6'(N_STATES));
  endfunction

endpackage

// File: rtl/q_episode_ctrl_next.sv
// Maze move: next state for (state, action), illegal on wall or block.
// An illegal move leaves the agent where it is.
module q_next_state
  import q_maze_pkg::*;
(
  input  state_t      state_i,
  input  action_e     action_i,
  input  logic [36:0] blocked_mask_i,
  output state_t      next_state_o,
  output logic        legal_o
);

  logic [5:0] col;

  assign col = 6'((state_i - 6'd1) % 6'(GRID_W));

  always_comb begin
    next_state_o = state_i;
    legal_o      = 1'b0;
    unique case (action_i)
      ACT_N: if (state_i > 6'd6) begin
        next_state_o = state_i - 6'd6;
        legal_o      = 1'b1;
      end
      ACT_E: if (col != 6'd5) begin
        next_state_o = state_i + 6'd1;
        legal_o      = 1'b1;
      end
      ACT_S: if (state_i <= 6'd30) begin
        next_state_o = state_i + 6'd6;
        legal_o      = 1'b1;
      end
      ACT_W: if (col != 6'd0) begin
        next_state_o = state_i - 6'd1;
        legal_o      = 1'b1;
      end
      default: ;
    endcase
    if (legal_o && blocked_mask_i[next_state_o]) begin
      next_state_o = state_i;
      legal_o      = 1'b0;
    end
  end

endmodule

// File: rtl/q_episode_ctrl.sv
// Q-learning episode sequencer owning the single Q-table RAM port.
// Optional epsilon-greedy exploration: define Q_EXPLORE_EN.
module q_episode_ctrl
  import q_maze_pkg::*;
#(
  parameter int unsigned NUM_EPISODES = 16,
  parameter int unsigned MAX_STEPS    = 255,
  parameter int unsigned ALPHA_SH     = 2,
  parameter int unsigned GAMMA_SH     = 3,
  parameter logic [31:0] REWARD       = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  start_state,
  input  logic [5:0]  target_state,
  input  logic [36:0] blocked_mask,
  output logic [7:0]  q_addr,
  output logic        q_rd_en,
  input  logic [31:0] q_rdata,
  output logic        q_wr_en,
  output logic [31:0] q_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  cur_state,
  output logic [15:0] episode_cnt,
  output logic [7:0]  step_cnt
);

  fsm_e     st_q;
  logic [2:0] rcnt_q;
  q_val_t   qv_q [4];
  q_val_t   nmax_q;
  action_e  act_q;
  state_t   cur_q, nxt_q;
  logic     hit_q, wall_q;
  logic     busy_q, done_q, err_q, rd_q, wr_q;
  logic [7:0]  addr_q, step_q;
  logic [15:0] ep_q;
  q_val_t   wdata_q;

  state_t   nstate;
  logic     legal;
  action_e  sel_act;
  logic [1:0] best, cidx;
  logic     cfg_ok;
  q_val_t   q_old, q_new, rwd;
  logic [33:0] td, qn;
  logic [8:0]  step_inc;
  logic [16:0] ep_inc;

  q_next_state u_next (
    .state_i        (cur_q),
    .action_i       (act_q),
    .blocked_mask_i (blocked_mask),
    .next_state_o   (nstate),
    .legal_o        (legal)
  );

  always_comb begin
    best = 2'd0;
    for (int i = 1; i < 4; i++)
      if (qv_q[i] > qv_q[best]) best = 2'(i);
  end

`ifdef Q_EXPLORE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0],
                        lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign sel_act = (lfsr_q[3:0] == 4'd0) ? action_e'(lfsr_q[5:4])
                                         : action_e'(best);
`else
  assign sel_act = action_e'(best);
`endif

  assign cfg_ok = on_grid(start_state) && on_grid(target_state) &&
                  !blocked_mask[start_state] && !blocked_mask[target_state];
  assign cidx     = 2'(rcnt_q - 3'd1);
  assign step_inc = {1'b0, step_q} + 9'd1;
  assign ep_inc   = {1'b0, ep_q} + 17'd1;

  // Unsigned TD update with headroom; only saturates on overflow past 32 bits
  assign q_old = qv_q[act_q];
  assign rwd   = hit_q ? REWARD : '0;
  assign td    = 34'(rwd) + 34'(nmax_q) - 34'(nmax_q >> GAMMA_SH);
  assign qn    = 34'(q_old) - 34'(q_old >> ALPHA_SH) + (td >> ALPHA_SH);
  assign q_new = (|qn[33:32]) ? 32'hFFFF_FFFF : qn[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      rcnt_q  <= '0;
      for (int i = 0; i < 4; i++) qv_q[i] <= '0;
      nmax_q  <= '0;
      act_q   <= ACT_N;
      cur_q   <= '0;
      nxt_q   <= '0;
      hit_q   <= 1'b0;
      wall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      step_q  <= '0;
      ep_q    <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        S_IDLE: if (start) begin
          st_q   <= S_CHECK;
          busy_q <= 1'b1;
          err_q  <= 1'b0;
          ep_q   <= '0;
        end
        S_CHECK: if (cfg_ok) begin
          st_q <= S_INIT;
        end else begin
          err_q  <= 1'b1;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          st_q   <= S_FIN;
        end
        S_INIT: begin
          cur_q  <= start_state;
          step_q <= '0;
          if (start_state == target_state) begin
            st_q <= S_EP_END;
          end else begin
            st_q   <= S_RD_CUR;
            rd_q   <= 1'b1;
            addr_q <= {start_state, 2'd0};
            rcnt_q <= '0;
          end
        end
        S_RD_CUR, S_RD_NXT: begin
          rcnt_q <= rcnt_q + 3'd1;
          if (rcnt_q < 3'd3) addr_q[1:0] <= 2'(rcnt_q + 3'd1);
          else               rd_q <= 1'b0;
          if (rcnt_q != 3'd0) begin
            if (st_q == S_RD_CUR)     qv_q[cidx] <= q_rdata;
            else if (q_rdata > nmax_q) nmax_q    <= q_rdata;
          end
          if (rcnt_q == 3'd4)
            st_q <= (st_q == S_RD_CUR) ? S_SELECT : S_UPDATE;
        end
        S_SELECT: begin
          act_q <= sel_act;
          st_q  <= S_MOVE;
        end
        S_MOVE: begin
          nxt_q  <= nstate;
          wall_q <= !legal;
          hit_q  <= legal && (nstate == target_state);
          nmax_q <= '0;
          if (!legal || nstate == target_state) begin
            st_q <= S_UPDATE;
          end else begin
            st_q   <= S_RD_NXT;
            rd_q   <= 1'b1;
            addr_q <= {nstate, 2'd0};
            rcnt_q <= '0;
          end
        end
        S_UPDATE: begin
          wr_q    <= 1'b1;
          addr_q  <= {cur_q, act_q};
          wdata_q <= wall_q ? '0 : q_new;
          st_q    <= S_WRITE;
        end
        S_WRITE: begin
          wr_q   <= 1'b0;
          cur_q  <= nxt_q;
          step_q <= step_inc[7:0];
          if (nxt_q == target_state || step_inc == 9'(MAX_STEPS)) begin
            st_q <= S_EP_END;
          end else begin
            st_q   <= S_RD_CUR;
            rd_q   <= 1'b1;
            addr_q <= {nxt_q, 2'd0};
            rcnt_q <= '0;
          end
        end
        S_EP_END: begin
          ep_q <= ep_inc[15:0];
          if (ep_inc < 17'(NUM_EPISODES)) begin
            st_q <= S_INIT;
          end else begin
            st_q   <= S_FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_FIN: st_q <= S_IDLE;
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign q_addr      = addr_q;
  assign q_rd_en     = rd_q;
  assign q_wr_en     = wr_q;
  assign q_wdata     = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cur_state   = cur_q;
  assign episode_cnt = ep_q;
  assign step_cnt    = step_q;

endmodule
